// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register sitting between data memory and the register-file
// write port. It aligns and extends load data and selects the write-back value.
// It also supports stall (hold), flush (bubble) and a synchronous reset, and
// counts retired instructions. All outputs are registered; WB_Data is only a mux
// of registered values.
//
// Ports
//   Clk, Rst                 clock, synchronous active-high reset
//   Stall, Flush             hold all registers / insert a bubble
//   In_Valid                 MEM-stage instruction is real
//   DM_RD                    raw data-memory read word
//   ALUResult_In             ALU result / address from MEM
//   AddrLow_In               byte offset of the load address
//   LoadSize_In              00 byte, 01 half, 10 word, 11 full width
//   LoadUnsigned_In          1 = zero-extend, 0 = sign-extend
//   WR_In                    destination register
//   RegWrite_In, MemtoReg_In, MemRead_In, Ctrl_In   control from MEM
//   Valid_Out, DM_ReadData, ALUResult, WB_Data, WriteReg,
//   C_RegWrite, C_MemtoReg, WB_MemRead, Ctrl_Out     WB-stage outputs
//   Retire_Count             number of valid instructions captured
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 1,
  parameter int CNT_W      = 32,
  localparam int LSB_W     = $clog2(DATA_W / 8)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  In_Valid,
  input  logic [DATA_W-1:0]     DM_RD,
  input  logic [DATA_W-1:0]     ALUResult_In,
  input  logic [LSB_W-1:0]      AddrLow_In,
  input  logic [1:0]            LoadSize_In,
  input  logic                  LoadUnsigned_In,
  input  logic [REG_ADDR_W-1:0] WR_In,
  input  logic                  RegWrite_In,
  input  logic                  MemtoReg_In,
  input  logic                  MemRead_In,
  input  logic [CTRL_W-1:0]     Ctrl_In,
  output logic                  Valid_Out,
  output logic [DATA_W-1:0]     DM_ReadData,
  output logic [DATA_W-1:0]     ALUResult,
  output logic [DATA_W-1:0]     WB_Data,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  C_RegWrite,
  output logic                  C_MemtoReg,
  output logic                  WB_MemRead,
  output logic [CTRL_W-1:0]     Ctrl_Out,
  output logic [CNT_W-1:0]      Retire_Count
);

  // A "word" is 32 bits, but on a 16-bit datapath it degenerates to full width.
  localparam int WORD_BITS = (DATA_W < 32) ? DATA_W : 32;

  localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] WORD_MASK = {DATA_W{1'b1}} >> (DATA_W - WORD_BITS);

  logic [LSB_W-1:0]  lane;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;

  // Lane extraction: align the lane down to the access size (misaligned low
  // bits are silently dropped), shift it to bit 0, then zero- or sign-extend
  // by masking the field and OR-ing ones above it when the sign bit is set.
  always_comb begin
    lane     = AddrLow_In;
    shifted  = DM_RD;
    load_ext = DM_RD;
    case (LoadSize_In)
      2'b00: begin
        lane     = AddrLow_In;
        shifted  = DM_RD >> {lane, 3'b000};
        load_ext = (LoadUnsigned_In || !shifted[7]) ? (shifted & BYTE_MASK)
                                                    : (shifted | ~BYTE_MASK);
      end
      2'b01: begin
        lane     = AddrLow_In & ~LSB_W'(1);
        shifted  = DM_RD >> {lane, 3'b000};
        load_ext = (LoadUnsigned_In || !shifted[15]) ? (shifted & HALF_MASK)
                                                     : (shifted | ~HALF_MASK);
      end
      2'b10: begin
        lane     = AddrLow_In & ~LSB_W'(3);
        shifted  = DM_RD >> {lane, 3'b000};
        load_ext = (LoadUnsigned_In || !shifted[WORD_BITS-1]) ? (shifted & WORD_MASK)
                                                              : (shifted | ~WORD_MASK);
      end
      default: begin
        load_ext = DM_RD;
      end
    endcase
  end

  // Pipeline register with priority Rst > Flush > Stall > capture. A flush
  // clears only the control/valid fields; data registers keep their values
  // since nothing consumes them in a bubble.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Valid_Out    <= 1'b0;
      DM_ReadData  <= '0;
      ALUResult    <= '0;
      WriteReg     <= '0;
      C_RegWrite   <= 1'b0;
      C_MemtoReg   <= 1'b0;
      WB_MemRead   <= 1'b0;
      Ctrl_Out     <= '0;
      Retire_Count <= '0;
    end else if (Flush) begin
      Valid_Out  <= 1'b0;
      WriteReg   <= '0;
      C_RegWrite <= 1'b0;
      C_MemtoReg <= 1'b0;
      WB_MemRead <= 1'b0;
      Ctrl_Out   <= '0;
    end else if (!Stall) begin
      Valid_Out   <= In_Valid;
      DM_ReadData <= load_ext;
      ALUResult   <= ALUResult_In;
      WriteReg    <= WR_In;
      // Register 0 is hard-wired, so a write to it is never enabled.
      C_RegWrite  <= RegWrite_In & In_Valid & (WR_In != '0);
      C_MemtoReg  <= MemtoReg_In & In_Valid;
      WB_MemRead  <= MemRead_In & In_Valid;
      Ctrl_Out    <= Ctrl_In;
      if (In_Valid) begin
        Retire_Count <= Retire_Count + CNT_W'(1);
      end
    end
  end

  assign WB_Data = C_MemtoReg ? DM_ReadData : ALUResult;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline register for the pipelined datapath, sitting between data memory and the register-file write port. On top of plain capture it adds a synchronous reset, a stall (hold) and a flush (bubble) input, and a valid bit. It also performs load-data lane extraction with sign or zero extension, selects the write-back value, and keeps a retired-instruction counter. All outputs are registered.

## Interface
- DATA_W, 32, datapath width; multiple of 8, at least 16.
- REG_ADDR_W, 5, register-file address width.
- CTRL_W, 1, width of the opaque pass-through control bus.
- CNT_W, 32, width of the retire counter.
- Derived: LSB_W = clog2(DATA_W/8).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Stall  in  1  hold all registers.
- Flush  in  1  insert a bubble.
- In_Valid  in  1  the MEM-stage instruction is real.
- DM_RD  in  DATA_W  raw data-memory read word.
- ALUResult_In  in  DATA_W  ALU result / address from MEM.
- AddrLow_In  in  LSB_W  byte offset of the load address.
- LoadSize_In  in  2  00 byte, 01 half, 10 word (32 bits), 11 full DATA_W.
- LoadUnsigned_In  in  1  1 = zero-extend, 0 = sign-extend.
- WR_In  in  REG_ADDR_W  destination register.
- RegWrite_In, MemtoReg_In, MemRead_In  in  1  control bits from MEM.
- Ctrl_In  in  CTRL_W  pass-through control.
- Valid_Out  out  1  WB-stage slot holds a real instruction.
- DM_ReadData  out  DATA_W  aligned, extended load data.
- ALUResult  out  DATA_W  registered ALU result.
- WB_Data  out  DATA_W  DM_ReadData if C_MemtoReg, else ALUResult.
- WriteReg  out  REG_ADDR_W  registered destination.
- C_RegWrite  out  1  qualified write enable.
- C_MemtoReg, WB_MemRead  out  1  registered control bits.
- Ctrl_Out  out  CTRL_W  registered pass-through.
- Retire_Count  out  CNT_W  number of valid instructions captured.

## Operation
- The priority on each rising edge is Rst > Flush > Stall > capture.
- **Rst:** every register and every output goes to 0, including Retire_Count.
- **Flush** (Stall ignored):
  - Valid_Out, C_RegWrite, C_MemtoReg, WB_MemRead, WriteReg and Ctrl_Out go to 0.
  - Data registers may hold their previous values.
  - Retire_Count is unchanged.
- **Stall** (no Flush): all registers hold, including Retire_Count.
- **Capture:**
  - Valid_Out <= In_Valid. All data and control fields load from their inputs.
  - C_RegWrite <= RegWrite_In & In_Valid & (WR_In != 0).
  - C_MemtoReg and WB_MemRead are gated by In_Valid.
  - Retire_Count increments by 1 when In_Valid=1. It wraps from all-ones to 0 with no flag.
- **Lane extraction** is combinational before the register:
  - Byte: the lane is AddrLow_In. Half: AddrLow_In with bit 0 cleared. Word: AddrLow_In with bits [1:0] cleared (misaligned low bits are ignored, never trapped).
  - The selected field is right-justified and extended to DATA_W per LoadUnsigned_In.
  - Size 11: DM_RD passes unchanged, AddrLow_In is ignored, and no extension applies.
  - Size 10 with DATA_W=32 is identical to 11.
  - Extraction applies regardless of MemRead_In. It is only consumed when C_MemtoReg=1.
- WB_Data is a combinational mux of registered values. It adds no extra latency.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on outputs after edge N.
- Throughput is 1 instruction per cycle when Stall=0.
- Stall held for k cycles freezes outputs for k cycles. Capture resumes on the first edge with Stall=0.
- Flush is effective for exactly one edge. A bubble has Valid_Out=0 and C_RegWrite=0.
- Rst asserted mid-stream clears on that edge. The first capture happens on the first edge after Rst deasserts.
- Simultaneous Flush+Stall produces a bubble. Simultaneous Rst+anything produces reset.
- Retire_Count is observable on the cycle after the capturing edge.

## Test plan
- **Reset:** drive all inputs nonzero with Rst=1 for 2 edges -> every output is 0 and Retire_Count=0. Deassert Rst, capture In_Valid=1, ALUResult_In=0x1234 -> ALUResult=0x1234 and Retire_Count=1 one cycle later.
- **Sign/zero extension:**
  - DM_RD=0x80FF7F01. Byte at offsets 0..3, signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Half at offset 2 unsigned -> 0x000080FF; signed -> 0xFFFF80FF.
  - Half at offset 3 -> same as offset 2.
- **Stall/flush:**
  - Capture WR_In=7 with RegWrite=1, then hold Stall=1 for 3 cycles with changing inputs -> outputs unchanged and Retire_Count unchanged.
  - Flush+Stall together -> Valid_Out=0, C_RegWrite=0, WriteReg=0.
- **Register-0 gating:** WR_In=0, RegWrite_In=1, In_Valid=1 -> C_RegWrite=0. Same with In_Valid=0 and WR_In=5 -> C_RegWrite=0 and Retire_Count is not incremented.
- **WB mux and back-to-back traffic:**
  - Alternate MemtoReg 1/0 every cycle with distinct DM_RD/ALUResult_In values -> WB_Data tracks the correct source each cycle, lagging the inputs by one cycle.
- **Counter wrap and DATA_W=64:**
  - With CNT_W=4, 17 valid captures -> Retire_Count=1.
  - With DATA_W=64 and size 10 at offset 4 on DM_RD=0x89ABCDEF_01234567, signed -> 0xFFFFFFFF_89ABCDEF.
